// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver/transmitter pair.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clock cycles per bit, truncated.
    function automatic int uart_cpb(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the input; both flops reset to the line's idle level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional parity, 1 or 2 stop
// bits, three-sample majority vote per bit, framing/break detection.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle; waits for rxs low while enabled (and re-armed)
// ST_START  | start bit; a high vote is a glitch and aborts
// ST_DATA   | payload bits, LSB first, counted by bcnt
// ST_PARITY | parity bit (skipped when PARITY is none)
// ST_STOP   | stop bit(s); frame resolves on the last stop bit's vote
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int BIT_RATE  = 9600,
    parameter int CLK_HZ    = 50000000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rxd,
    input  logic                 uart_rx_en,
    output logic                 uart_rx_valid,
    output logic [DATA_BITS-1:0] uart_rx_data,
    output logic                 uart_rx_parity_err,
    output logic                 uart_rx_frame_err,
    output logic                 uart_rx_break
);

    localparam int CPB  = uart_cpb(CLK_HZ, BIT_RATE);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int BW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0] C_HM1  = CW'(HALF - 1);
    localparam logic [CW-1:0] C_HALF = CW'(HALF);
    localparam logic [CW-1:0] C_DEC  = CW'(HALF + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic          S_LAST = 1'(STOP_BITS - 1);

    if (CPB < 8) begin : g_bad_cpb
        $error("uart_rx_cfg: CLK_HZ/BIT_RATE must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end

    uart_state_t          state, state_n;
    logic [CW-1:0]        ccnt, ccnt_n;
    logic [BW-1:0]        bcnt, bcnt_n;
    logic                 scnt, scnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_bit, par_n;
    logic                 samp_a, samp_a_n, samp_b, samp_b_n;
    logic                 all_zero, zero_n;   // every voted bit so far was 0
    logic                 stop_bad, sbad_n;   // an earlier stop bit was 0
    logic                 armed, armed_n;     // cleared by a break until line returns high
    logic                 valid_n, ferr_n, brk_n, perr_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 rxs, vote, par_x, perr_calc, stop_bad_now, zero_now;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (uart_rxd),
        .q     (rxs)
    );

    // Third sample is rxs itself on the decision cycle.
    assign vote  = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
    assign par_x = (^shreg) ^ par_bit;
    assign perr_calc = (PARITY == PAR_ODD)  ? ~par_x :
                       (PARITY == PAR_EVEN) ?  par_x : 1'b0;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= ST_IDLE;
            ccnt               <= '0;
            bcnt               <= '0;
            scnt               <= 1'b0;
            shreg              <= '0;
            par_bit            <= 1'b0;
            samp_a             <= 1'b1;
            samp_b             <= 1'b1;
            all_zero           <= 1'b1;
            stop_bad           <= 1'b0;
            armed              <= 1'b1;
            uart_rx_valid      <= 1'b0;
            uart_rx_frame_err  <= 1'b0;
            uart_rx_break      <= 1'b0;
            uart_rx_parity_err <= 1'b0;
            uart_rx_data       <= '0;
        end else begin
            state              <= state_n;
            ccnt               <= ccnt_n;
            bcnt               <= bcnt_n;
            scnt               <= scnt_n;
            shreg              <= shreg_n;
            par_bit            <= par_n;
            samp_a             <= samp_a_n;
            samp_b             <= samp_b_n;
            all_zero           <= zero_n;
            stop_bad           <= sbad_n;
            armed              <= armed_n;
            uart_rx_valid      <= valid_n;
            uart_rx_frame_err  <= ferr_n;
            uart_rx_break      <= brk_n;
            uart_rx_parity_err <= perr_n;
            uart_rx_data       <= data_n;
        end
    end

    // Next-state, bit voting and frame resolution.
    always_comb begin
        state_n      = state;
        ccnt_n       = ccnt;
        bcnt_n       = bcnt;
        scnt_n       = scnt;
        shreg_n      = shreg;
        par_n        = par_bit;
        zero_n       = all_zero;
        sbad_n       = stop_bad;
        armed_n      = armed;
        valid_n      = 1'b0;
        ferr_n       = 1'b0;
        brk_n        = 1'b0;
        perr_n       = uart_rx_parity_err;
        data_n       = uart_rx_data;
        samp_a_n     = samp_a;
        samp_b_n     = samp_b;
        stop_bad_now = stop_bad | ~vote;
        zero_now     = all_zero & ~vote;

        if (ccnt == C_HM1)  samp_a_n = rxs;
        if (ccnt == C_HALF) samp_b_n = rxs;

        case (state)
            ST_IDLE: begin
                ccnt_n = '0;
                bcnt_n = '0;
                scnt_n = 1'b0;
                zero_n = 1'b1;
                sbad_n = 1'b0;
                if (rxs) armed_n = 1'b1;
                if (armed && !rxs && uart_rx_en) state_n = ST_START;
            end
            ST_START: begin
                ccnt_n = ccnt + CW'(1);
                if (ccnt == C_DEC && vote) begin
                    state_n = ST_IDLE;
                    ccnt_n  = '0;
                end else if (ccnt == C_LAST) begin
                    state_n = ST_DATA;
                    ccnt_n  = '0;
                end
            end
            ST_DATA: begin
                ccnt_n = ccnt + CW'(1);
                if (ccnt == C_DEC) begin
                    shreg_n = {vote, shreg[DATA_BITS-1:1]};
                    if (vote) zero_n = 1'b0;
                end
                if (ccnt == C_LAST) begin
                    ccnt_n = '0;
                    if (bcnt == B_LAST) begin
                        bcnt_n  = '0;
                        state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bcnt_n = bcnt + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                ccnt_n = ccnt + CW'(1);
                if (ccnt == C_DEC) begin
                    par_n = vote;
                    if (vote) zero_n = 1'b0;
                end
                if (ccnt == C_LAST) begin
                    ccnt_n  = '0;
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                ccnt_n = ccnt + CW'(1);
                if (ccnt == C_DEC && scnt == S_LAST) begin
                    // Resolve early so a following start bit is not missed.
                    state_n = ST_IDLE;
                    ccnt_n  = '0;
                    scnt_n  = 1'b0;
                    if (!stop_bad_now) begin
                        valid_n = 1'b1;
                        data_n  = shreg;
                        perr_n  = perr_calc;
                    end else if (zero_now) begin
                        brk_n   = 1'b1;
                        armed_n = 1'b0;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end else begin
                    if (ccnt == C_DEC) begin
                        sbad_n = stop_bad_now;
                        zero_n = zero_now;
                    end
                    if (ccnt == C_LAST) begin
                        ccnt_n = '0;
                        scnt_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                ccnt_n  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed scoreboard bench for uart_rx_cfg in 8N1, 7E1 and 8N2 configurations.
module tb_uart_rx_cfg;

    localparam int CPB = 10;

    typedef struct {
        int         inst;
        logic [2:0] kind;   // {break, frame_err, valid}
        logic [8:0] data;
        logic       perr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rxd0 = 1'b1, rxd1 = 1'b1, rxd2 = 1'b1;
    logic en0 = 1'b1, en1 = 1'b1, en2 = 1'b1;

    logic       vld0, pe0, fe0, bk0;
    logic [7:0] data0;
    logic       vld1, pe1, fe1, bk1;
    logic [6:0] data1;
    logic       vld2, pe2, fe2, bk2;
    logic [7:0] data2;

    always #5 clk = ~clk;

    uart_rx_cfg #(.BIT_RATE(100000), .CLK_HZ(1000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .reset(reset), .uart_rxd(rxd0), .uart_rx_en(en0),
        .uart_rx_valid(vld0), .uart_rx_data(data0), .uart_rx_parity_err(pe0),
        .uart_rx_frame_err(fe0), .uart_rx_break(bk0));

    uart_rx_cfg #(.BIT_RATE(100000), .CLK_HZ(1000000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .reset(reset), .uart_rxd(rxd1), .uart_rx_en(en1),
        .uart_rx_valid(vld1), .uart_rx_data(data1), .uart_rx_parity_err(pe1),
        .uart_rx_frame_err(fe1), .uart_rx_break(bk1));

    uart_rx_cfg #(.BIT_RATE(100000), .CLK_HZ(1000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .reset(reset), .uart_rxd(rxd2), .uart_rx_en(en2),
        .uart_rx_valid(vld2), .uart_rx_data(data2), .uart_rx_parity_err(pe2),
        .uart_rx_frame_err(fe2), .uart_rx_break(bk2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int inst, input logic [2:0] kind, input logic [8:0] d, input logic p);
        exp_t e;
        e.inst = inst;
        e.kind = kind;
        e.data = d;
        e.perr = p;
        sb.push_back(e);
    endtask

    // Any output pulse must match the oldest outstanding expectation.
    task automatic mon(input int i, input logic vld, input logic fe, input logic bk,
                       input logic perr, input logic [8:0] d);
        exp_t e;
        if (vld | fe | bk) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL u%0d_unexpected_pulse: observed kind %b expected none", i, {bk, fe, vld});
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk($sformatf("u%0d_inst", i), 32'(i), 32'(e.inst));
                chk($sformatf("u%0d_kind", i), 32'({bk, fe, vld}), 32'(e.kind));
                chk($sformatf("u%0d_data", i), 32'(d), 32'(e.data));
                chk($sformatf("u%0d_perr", i), 32'(perr), 32'(e.perr));
            end
        end
    endtask

    // Scoreboard consumer, sampling away from the active edge.
    always @(negedge clk) begin
        mon(0, vld0, fe0, bk0, pe0, {1'b0, data0});
        mon(1, vld1, fe1, bk1, pe1, {2'b0, data1});
        mon(2, vld2, fe2, bk2, pe2, {1'b0, data2});
    end

    task automatic drive(input int inst, input logic b);
        case (inst)
            0:       rxd0 = b;
            1:       rxd1 = b;
            default: rxd2 = b;
        endcase
    endtask

    // Bits go out LSB first; bit index spike_at gets a one-cycle low pulse mid-bit.
    task automatic send_bits(input int inst, input logic [15:0] v, input int n, input int spike_at);
        for (int i = 0; i < n; i++) begin
            if (i == spike_at) begin
                drive(inst, v[i]);
                repeat (5) @(negedge clk);
                drive(inst, 1'b0);
                @(negedge clk);
                drive(inst, v[i]);
                repeat (4) @(negedge clk);
            end else begin
                drive(inst, v[i]);
                repeat (CPB) @(negedge clk);
            end
        end
        drive(inst, 1'b1);
    endtask

    function automatic logic [15:0] f8n1(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [15:0] f7p1(input logic [6:0] d, input logic p);
        return {6'b0, 1'b1, p, d, 1'b0};
    endfunction

    function automatic logic [15:0] f8n2(input logic [7:0] d, input logic s2);
        return {5'b0, s2, 1'b1, d, 1'b0};
    endfunction

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 4 * CPB) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL %s_timeout: observed %0d pending expected 0", tag, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_u0_data",  32'(data0), 32'h0);
        chk("rst_u0_valid", 32'(vld0), 32'h0);
        chk("rst_u0_ferr",  32'(fe0), 32'h0);
        chk("rst_u0_brk",   32'(bk0), 32'h0);
        chk("rst_u1_data",  32'(data1), 32'h0);
        chk("rst_u1_perr",  32'(pe1), 32'h0);
        chk("rst_u2_data",  32'(data2), 32'h0);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        // 8N1 basic frame
        push(0, 3'b001, 9'h0A5, 1'b0);
        send_bits(0, f8n1(8'hA5), 10, -1);
        wait_drain("8n1_a5");

        // disabled receiver ignores a frame
        en0 = 1'b0;
        send_bits(0, f8n1(8'h99), 10, -1);
        repeat (CPB) @(negedge clk);
        en0 = 1'b1;
        repeat (CPB) @(negedge clk);
        chk("disabled_data_held", 32'(data0), 32'hA5);

        // 7E1 good parity, then bad parity
        push(1, 3'b001, 9'h035, 1'b0);
        send_bits(1, f7p1(7'h35, 1'b0), 10, -1);
        wait_drain("7e1_ok");
        push(1, 3'b001, 9'h035, 1'b1);
        send_bits(1, f7p1(7'h35, 1'b1), 10, -1);
        wait_drain("7e1_perr");

        // 8N2 good frame, then second stop bit low
        push(2, 3'b001, 9'h0C3, 1'b0);
        send_bits(2, f8n2(8'hC3, 1'b1), 11, -1);
        wait_drain("8n2_ok");
        push(2, 3'b010, 9'h0C3, 1'b0);
        send_bits(2, f8n2(8'h3C, 1'b0), 11, -1);
        wait_drain("8n2_ferr");
        repeat (CPB) @(negedge clk);

        // break: line low for 12 bit times, then recover
        push(0, 3'b100, 9'h0A5, 1'b0);
        rxd0 = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        rxd0 = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        wait_drain("break");
        push(0, 3'b001, 9'h055, 1'b0);
        send_bits(0, f8n1(8'h55), 10, -1);
        wait_drain("after_break_55");

        // short glitch on idle line
        repeat (CPB) @(negedge clk);
        rxd0 = 1'b0;
        repeat (3) @(negedge clk);
        rxd0 = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch_data_held", 32'(data0), 32'h55);

        // spike at the centre of data bit 3 of 0xFF
        push(0, 3'b001, 9'h0FF, 1'b0);
        send_bits(0, f8n1(8'hFF), 10, 4);
        wait_drain("spike_ff");
        repeat (CPB) @(negedge clk);

        // reset in the middle of 0x81's data bits
        send_bits(0, 16'b0010, 4, -1);
        rxd0 = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        rxd0 = 1'b1;
        #1;
        chk("midrst_data",  32'(data0), 32'h0);
        chk("midrst_valid", 32'(vld0), 32'h0);
        chk("midrst_ferr",  32'(fe0), 32'h0);
        chk("midrst_brk",   32'(bk0), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (CPB) @(negedge clk);

        // back-to-back frames with no idle between them
        push(0, 3'b001, 9'h012, 1'b0);
        push(0, 3'b001, 9'h034, 1'b0);
        send_bits(0, f8n1(8'h12), 10, -1);
        send_bits(0, f8n1(8'h34), 10, -1);
        wait_drain("b2b");
        repeat (2 * CPB) @(negedge clk);
        chk("final_data", 32'(data0), 32'h34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
